maxnet_controller: RTL and testbench

- FSM that sequences the 4-lane max-finding datapath: loads the four input numbers, then iterates activation → multiply → add → main-register update until the datapath raises found.
- Drives every datapath write strobe and the four input-mux selects; the datapath's found is its only feedback.
- Sits beside the datapath in the top level; the top level supplies start and reads done/busy/iter_count.

---
 rtl/maxnet_controller.sv | 125 ++++++++++++
 tb/tb_maxnet_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-lane max-finding datapath: load, then ACT/MULT/ADD/UPDATE/CHECK until found.
// Optional iteration limit enabled by defining MAXNET_TIMEOUT_EN (uses MAX_ITER).
module maxnet_controller #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              found,
    output logic              main_write,
    output logic              actWrite,
    output logic              multWrite,
    output logic              addWrite,
    output logic              mainRegWrite,
    output logic              s1,
    output logic              s2,
    output logic              s3,
    output logic              s4,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACT,
        ST_MULT,
        ST_ADD,
        ST_UPDATE,
        ST_CHECK,
        ST_DONE
    } state_e;

    if (MAX_ITER < 1 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_bad_max_iter
        $error("maxnet_controller: MAX_ITER out of range for ITER_W");
    end

    state_e            state_q, state_d;
    logic              first_iter_q, first_iter_d;
    logic [ITER_W-1:0] iter_count_q, iter_count_d;
    logic              timeout_q, timeout_d;
    logic              limit_hit;

`ifdef MAXNET_TIMEOUT_EN
    assign limit_hit = (iter_count_q == ITER_W'(MAX_ITER));
`else
    assign limit_hit = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            first_iter_q <= 1'b1;
            iter_count_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_iter_q <= first_iter_d;
            iter_count_q <= iter_count_d;
            timeout_q    <= timeout_d;
        end
    end

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        first_iter_d = first_iter_q;
        iter_count_d = iter_count_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                iter_count_d = '0;
                timeout_d    = 1'b0;
                first_iter_d = 1'b1;
                state_d      = ST_ACT;
            end
            ST_ACT:  state_d = ST_MULT;
            ST_MULT: state_d = ST_ADD;
            ST_ADD:  state_d = ST_UPDATE;
            ST_UPDATE: begin
                first_iter_d = 1'b0;
                if (iter_count_q != '1) iter_count_d = iter_count_q + 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // found outranks the iteration limit when both occur together
                if (found) begin
                    state_d = ST_DONE;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_ACT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic act_feedback;
    assign act_feedback = (state_q == ST_ACT) && !first_iter_q;

    assign main_write   = (state_q == ST_LOAD);
    assign actWrite     = (state_q == ST_ACT);
    assign multWrite    = (state_q == ST_MULT);
    assign addWrite     = (state_q == ST_ADD);
    assign mainRegWrite = (state_q == ST_UPDATE);
    assign s1           = act_feedback;
    assign s2           = act_feedback;
    assign s3           = act_feedback;
    assign s4           = act_feedback;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign iter_count   = iter_count_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: cycle-exact strobe traces against hand-derived tables.
module tb_maxnet_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       found = 1'b0;
    logic       main_write, actWrite, multWrite, addWrite, mainRegWrite;
    logic       s1, s2, s3, s4, busy, done, timeout;
    logic [7:0] iter_count;

    int n_checks = 0;
    int n_errors = 0;

    // Observation vector: {main_write, act, mult, add, mainReg, s1..s4, busy, done}
    localparam logic [10:0] O_IDLE = 11'b0_0_0_0_0_0000_0_0;
    localparam logic [10:0] O_LOAD = 11'b1_0_0_0_0_0000_1_0;
    localparam logic [10:0] O_ACT0 = 11'b0_1_0_0_0_0000_1_0;
    localparam logic [10:0] O_ACT1 = 11'b0_1_0_0_0_1111_1_0;
    localparam logic [10:0] O_MULT = 11'b0_0_1_0_0_0000_1_0;
    localparam logic [10:0] O_ADD  = 11'b0_0_0_1_0_0000_1_0;
    localparam logic [10:0] O_UPD  = 11'b0_0_0_0_1_0000_1_0;
    localparam logic [10:0] O_CHK  = 11'b0_0_0_0_0_0000_1_0;
    localparam logic [10:0] O_DONE = 11'b0_0_0_0_0_0000_1_1;

    logic [10:0] tr_obs  [64];
    logic [7:0]  tr_iter [64];
    logic        tr_to   [64];

    maxnet_controller #(.ITER_W(8), .MAX_ITER(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .found        (found),
        .main_write   (main_write),
        .actWrite     (actWrite),
        .multWrite    (multWrite),
        .addWrite     (addWrite),
        .mainRegWrite (mainRegWrite),
        .s1           (s1),
        .s2           (s2),
        .s3           (s3),
        .s4           (s4),
        .busy         (busy),
        .done         (done),
        .iter_count   (iter_count),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle c starts 1 time unit after a rising edge; inputs for cycle c are driven then,
    // and outputs (all registered) are recorded at the same point.
    task automatic run_seq(input logic [63:0] start_m, input logic [63:0] found_m,
                           input logic [63:0] rst_m, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rst   = ~rst_m[c];
            start = start_m[c];
            found = found_m[c];
            tr_obs[c]  = {main_write, actWrite, multWrite, addWrite, mainRegWrite,
                          s1, s2, s3, s4, busy, done};
            tr_iter[c] = iter_count;
            tr_to[c]   = timeout;
            @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        start = 1'b0;
        found = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset for two cycles, then ten idle cycles
        run_seq(64'h0, 64'h0, 64'h3, 12);
        for (int c = 2; c < 12; c++) check($sformatf("rst_idle_obs_c%0d", c), 32'(tr_obs[c]), 32'(O_IDLE));
        check("rst_idle_iter", 32'(tr_iter[11]), 32'd0);
        check("rst_idle_timeout", 32'(tr_to[11]), 32'd0);

        // Single iteration: found held high from cycle 6
        run_seq(64'h1, ~64'h3f, 64'h0, 10);
        check("one_load",   32'(tr_obs[1]), 32'(O_LOAD));
        check("one_act",    32'(tr_obs[2]), 32'(O_ACT0));
        check("one_mult",   32'(tr_obs[3]), 32'(O_MULT));
        check("one_add",    32'(tr_obs[4]), 32'(O_ADD));
        check("one_update", 32'(tr_obs[5]), 32'(O_UPD));
        check("one_check",  32'(tr_obs[6]), 32'(O_CHK));
        check("one_done",   32'(tr_obs[7]), 32'(O_DONE));
        check("one_idle",   32'(tr_obs[8]), 32'(O_IDLE));
        check("one_iter",   32'(tr_iter[7]), 32'd1);

        // Three iterations; found pulses at 5 and 10 fall outside CHECK
        run_seq(64'h1, (64'h1 << 5) | (64'h1 << 10) | (64'h1 << 16), 64'h0, 22);
        check("three_act1",   32'(tr_obs[2]),  32'(O_ACT0));
        check("three_chk1",   32'(tr_obs[6]),  32'(O_CHK));
        check("three_act2",   32'(tr_obs[7]),  32'(O_ACT1));
        check("three_chk2",   32'(tr_obs[11]), 32'(O_CHK));
        check("three_act3",   32'(tr_obs[12]), 32'(O_ACT1));
        check("three_mult3",  32'(tr_obs[13]), 32'(O_MULT));
        check("three_chk3",   32'(tr_obs[16]), 32'(O_CHK));
        check("three_done",   32'(tr_obs[17]), 32'(O_DONE));
        check("three_idle",   32'(tr_obs[18]), 32'(O_IDLE));
        check("three_iter",   32'(tr_iter[17]), 32'd3);
        check("three_hold",   32'(tr_iter[21]), 32'd3);

        // Reset in cycle 9 aborts the second iteration
        run_seq(64'h1, 64'h0, 64'h1 << 9, 12);
        check("abort_pre_iter",  32'(tr_iter[9]),  32'd1);
        check("abort_pre_obs",   32'(tr_obs[9]),   32'(O_ADD));
        check("abort_post_obs",  32'(tr_obs[10]),  32'(O_IDLE));
        check("abort_post_iter", 32'(tr_iter[10]), 32'd0);
        check("abort_still",     32'(tr_obs[11]),  32'(O_IDLE));
        run_seq(64'h1, 64'h1 << 6, 64'h0, 9);
        check("restart_act",  32'(tr_obs[2]),  32'(O_ACT0));
        check("restart_done", 32'(tr_obs[7]),  32'(O_DONE));
        check("restart_iter", 32'(tr_iter[7]), 32'd1);

        // start held through a 2-iteration search, then released after the second LOAD
        run_seq(64'h7fff, (64'h1 << 11) | (64'h1 << 19), 64'h0, 23);
        check("held_update1", 32'(tr_obs[5]),  32'(O_UPD));
        check("held_act2",    32'(tr_obs[7]),  32'(O_ACT1));
        check("held_done",    32'(tr_obs[12]), 32'(O_DONE));
        check("held_idle",    32'(tr_obs[13]), 32'(O_IDLE));
        check("held_iter",    32'(tr_iter[12]), 32'd2);
        check("held_reload",  32'(tr_obs[14]), 32'(O_LOAD));
        check("held_reiter",  32'(tr_iter[15]), 32'd0);
        check("held_react",   32'(tr_obs[15]), 32'(O_ACT0));
        check("held_redone",  32'(tr_obs[20]), 32'(O_DONE));
        check("held_reiter2", 32'(tr_iter[20]), 32'd1);
        check("held_final",   32'(tr_obs[21]), 32'(O_IDLE));

`ifdef MAXNET_TIMEOUT_EN
        // Limit of 4 iterations with no convergence
        run_seq(64'h1, 64'h0, 64'h0, 25);
        check("to_chk4",    32'(tr_obs[21]), 32'(O_CHK));
        check("to_done",    32'(tr_obs[22]), 32'(O_DONE));
        check("to_flag",    32'(tr_to[22]),  32'd1);
        check("to_iter",    32'(tr_iter[22]), 32'd4);
        check("to_idle",    32'(tr_obs[23]), 32'(O_IDLE));
        check("to_hold",    32'(tr_to[24]),  32'd1);
        // found wins over the limit in the same CHECK
        run_seq(64'h1, 64'h1 << 21, 64'h0, 25);
        check("to_cleared", 32'(tr_to[2]),   32'd0);
        check("tf_done",    32'(tr_obs[22]), 32'(O_DONE));
        check("tf_flag",    32'(tr_to[22]),  32'd0);
        check("tf_iter",    32'(tr_iter[22]), 32'd4);
`else
        // Without the limit the search keeps going past 4 iterations
        run_seq(64'h1, 64'h1 << 26, 64'h0, 29);
        check("nolim_chk4",  32'(tr_obs[21]), 32'(O_CHK));
        check("nolim_act5",  32'(tr_obs[22]), 32'(O_ACT1));
        check("nolim_to",    32'(tr_to[22]),  32'd0);
        check("nolim_done",  32'(tr_obs[27]), 32'(O_DONE));
        check("nolim_iter",  32'(tr_iter[27]), 32'd5);
        check("nolim_to_end", 32'(tr_to[27]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
